// File: rtl/buf_rd_streamer.sv
// buf_rd_streamer: read-side controller for the 1024x64 activation/weight buffer.
// Turns a (base, len) command into buffer reads (1-cycle read latency) and
// presents the returned words as a valid/ready stream with a last-beat marker.
// A 2-entry output FIFO absorbs the read latency so backpressure never loses data.
// Optional feature macro: BUF_RD_STRIDE_EN (adds a stride input latched with start;
// without it the address increment is fixed at 1).
module buf_rd_streamer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clkb,
  input  logic              rstb_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
`ifdef BUF_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_pop_left;
`ifdef BUF_RD_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;
`endif

  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_enb;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W:0]   w_addr_sum;
  logic [ADDR_W-1:0] w_addr_nxt;

`ifdef BUF_RD_STRIDE_EN
  assign w_step = r_stride;
`else
  assign w_step = ADDR_W'(1);
`endif

  // Stream handshake and output FIFO head
  assign w_pop   = m_valid & m_ready;
  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_mem[r_rptr];
  assign m_last  = m_valid && (r_pop_left == (ADDR_W+1)'(1));

  // Words held in the FIFO plus the one in flight, net of this cycle's pop.
  // Keeping this below 2 guarantees every returning word has a FIFO slot.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_enb = (r_state == S_RUN) && (r_remaining != '0) && (w_occ < 3'd2);

  assign enb   = w_enb;
  assign addrb = r_addr;
  assign busy  = r_busy;
  assign done  = r_done;

  // Address advance with explicit modulo-DEPTH wrap (also correct for non-power-of-2 DEPTH)
  assign w_addr_sum = {1'b0, r_addr} + {1'b0, w_step};
  assign w_addr_nxt = (w_addr_sum >= DEPTH_W) ? ADDR_W'(w_addr_sum - DEPTH_W)
                                              : ADDR_W'(w_addr_sum);

  // Command FSM: latches the command, walks the address counter, tracks beats still owed
  always_ff @(posedge clkb) begin
    if (!rstb_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_pop_left  <= '0;
`ifdef BUF_RD_STRIDE_EN
      r_stride    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr <= base_addr;
`ifdef BUF_RD_STRIDE_EN
            r_stride <= stride;
`endif
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state     <= S_RUN;
              r_remaining <= len;
              r_pop_left  <= len;
            end else begin
              // Empty command: no reads, straight to the completion pulse
              r_state     <= S_FIN;
              r_done      <= 1'b1;
              r_remaining <= '0;
              r_pop_left  <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_enb) begin
            r_addr      <= w_addr_nxt;
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
          end
          if (w_pop) begin
            r_pop_left <= r_pop_left - (ADDR_W+1)'(1);
          end
          if (w_pop && m_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Return path: capture buffer data one cycle after each read into the 2-entry FIFO
  always_ff @(posedge clkb) begin
    if (!rstb_n) begin
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_inflight <= w_enb;
      if (r_inflight) begin
        r_mem[r_wptr] <= doutb;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
